// File: rtl/ptr_cl_pkg.sv
// ptr_cl_pkg -- definitions shared by the cacheline response tracker and its bench.
//   TAG_WIDTH_DEF : default width of a cacheline request tag
//   STAT_WIDTH    : width of the optional statistics counters
//   cl_rsp_t      : {tag, err} layout of one response entry at the default tag width
package ptr_cl_pkg;

  localparam int TAG_WIDTH_DEF = 8;
  localparam int STAT_WIDTH    = 32;

  typedef struct packed {
    logic [TAG_WIDTH_DEF-1:0] tag;
    logic                     err;
  } cl_rsp_t;

endpackage

// File: rtl/ptr_cl_rsp_fifo.sv
// ptr_cl_rsp_fifo -- synchronous FIFO with first-word fall-through read.
//   clk, reset     : clock, asynchronous active-high reset (pointers only)
//   push/push_data : write one entry when not full
//   pop/pop_data   : pop_data always shows the head entry; pop advances it when not empty
//   full/empty     : occupancy flags derived from pointers carrying one extra wrap bit
module ptr_cl_rsp_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [width-1:0] mem [depth];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the pointers,
  // so stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Same low bits: equal wrap bits mean empty, different wrap bits mean full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ptr_cl_rsp.sv
// ptr_cl_rsp -- tracks cacheline reads from ptr_st: issues them to memory,
// matches in-order memory completions to their tags and returns {tag, err}
// responses in acceptance order.
//   clk, reset                    : clock, asynchronous active-high reset
//   i_clreq_v/i_clreq_r/i_clreq_tag : request from ptr_st
//   o_mem_v/o_mem_r/o_mem_tag     : memory read issue (held until o_mem_r)
//   i_mem_rsp_v/i_mem_rsp_err     : memory completion, issue order, no backpressure
//   o_clrsp_v/o_clrsp_r           : response to ptr_st
//   o_clrsp_tag/o_clrsp_err       : response payload
//   o_idle                        : nothing outstanding
//   o_proto_err                   : sticky, completion arrived with nothing outstanding
//   o_stat_req/o_stat_full        : saturating statistics, only with PTR_CL_RSP_STAT_EN
module ptr_cl_rsp
  import ptr_cl_pkg::*;
#(
  parameter int tag_width = TAG_WIDTH_DEF,
  parameter int depth     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clreq_v,
  output logic                 i_clreq_r,
  input  logic [tag_width-1:0] i_clreq_tag,
  output logic                 o_mem_v,
  input  logic                 o_mem_r,
  output logic [tag_width-1:0] o_mem_tag,
  input  logic                 i_mem_rsp_v,
  input  logic                 i_mem_rsp_err,
  output logic                 o_clrsp_v,
  input  logic                 o_clrsp_r,
  output logic [tag_width-1:0] o_clrsp_tag,
  output logic                 o_clrsp_err,
  output logic                 o_idle,
  output logic                 o_proto_err
`ifdef PTR_CL_RSP_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0] o_stat_req,
  output logic [STAT_WIDTH-1:0] o_stat_full
`endif
);

  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          rdy_en;
  logic          req_hs;
  logic          rsp_hs;
  logic          cnt_full;

  logic                 tag_full;
  logic                 tag_empty;
  logic [tag_width-1:0] tag_head;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic [tag_width:0]   rsp_head;
  logic                 mem_rsp_ok;

  assign cnt_full = (cnt == CW'(depth));
  assign req_hs   = i_clreq_v && i_clreq_r;
  assign rsp_hs   = o_clrsp_v && o_clrsp_r;

  // rdy_en holds ready low through reset and rises on the first edge after it.
  assign i_clreq_r = rdy_en && !cnt_full && !tag_full && (!o_mem_v || o_mem_r);

  // A completion is only meaningful when a tag is waiting for it.
  assign mem_rsp_ok = i_mem_rsp_v && !tag_empty && !rsp_full;

  // NOTE: every signal assigned in always_comb gets a default first,
  // otherwise a missed branch infers a latch.
  always_comb begin
    cnt_next = cnt;
    case ({req_hs, rsp_hs})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rdy_en      <= 1'b0;
      o_mem_v     <= 1'b0;
      o_mem_tag   <= '0;
      o_proto_err <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      rdy_en <= 1'b1;
      if (req_hs) begin
        o_mem_v   <= 1'b1;
        o_mem_tag <= i_clreq_tag;
      end else if (o_mem_r) begin
        o_mem_v <= 1'b0;
      end
      if (i_mem_rsp_v && !mem_rsp_ok) o_proto_err <= 1'b1;
    end
  end

  ptr_cl_rsp_fifo #(
    .width (tag_width),
    .depth (depth)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_hs),
    .push_data (i_clreq_tag),
    .pop       (mem_rsp_ok),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  ptr_cl_rsp_fifo #(
    .width (tag_width + 1),
    .depth (depth)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_rsp_ok),
    .push_data ({tag_head, i_mem_rsp_err}),
    .pop       (rsp_hs),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  // The registered push makes a response visible exactly one cycle after its completion.
  assign o_clrsp_v   = !rsp_empty;
  assign o_clrsp_tag = rsp_head[tag_width:1];
  assign o_clrsp_err = rsp_head[0];
  assign o_idle      = (cnt == '0);

`ifdef PTR_CL_RSP_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stat_req  <= '0;
      o_stat_full <= '0;
    end else begin
      if (req_hs && (o_stat_req != '1))
        o_stat_req <= o_stat_req + STAT_WIDTH'(1);
      if (i_clreq_v && cnt_full && (o_stat_full != '1))
        o_stat_full <= o_stat_full + STAT_WIDTH'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
